// File: rtl/nv_fifo_rwsp_128x6_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nv_fifo_rwsp_128x6_pkg
// Description : Shared sizing constants for the 128x6 rwsp-RAM-backed FIFO.
//               DEPTH/WIDTH are fixed by the RAM macro; AW addresses it and
//               CW holds an occupancy of 0..DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
package nv_fifo_rwsp_128x6_pkg;
    localparam int DEPTH = 128;
    localparam int WIDTH = 6;
    localparam int AW    = 7;
    localparam int CW    = AW + 1;
endpackage
`default_nettype wire

// File: rtl/nv_ram_rwsp_128x6.sv
`default_nettype none
// ============================================================================
// Module      : nv_ram_rwsp_128x6
// Description : 128x6 RAM with a two-stage registered read port.
//               re_i captures ra_i into an address register; ore_i captures
//               the addressed word into the output register (dout_o).
//               One write port (wa_i/we_i/di_i). Contents are not reset.
// Ports       : clk, ra_i/re_i/ore_i/dout_o (read), wa_i/we_i/di_i (write),
//               pwrbus_ram_pd_i (power control, no functional effect here).
// Revision    : 1.0 - initial release
// ============================================================================
module nv_ram_rwsp_128x6
    import nv_fifo_rwsp_128x6_pkg::*;
(
    input  logic             clk,
    input  logic [AW-1:0]    ra_i,
    input  logic             re_i,
    input  logic             ore_i,
    output logic [WIDTH-1:0] dout_o,
    input  logic [AW-1:0]    wa_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] di_i,
    input  logic [31:0]      pwrbus_ram_pd_i
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ra_q;
    logic [WIDTH-1:0] dout_q;

    // Power-bus pins only matter to the physical macro.
    logic w_pwrbus_unused;
    assign w_pwrbus_unused = ^pwrbus_ram_pd_i;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wa_i] <= di_i;
        end
        if (re_i) begin
            ra_q <= ra_i;
        end
        if (ore_i) begin
            dout_q <= mem_q[ra_q];
        end
    end

    assign dout_o = dout_q;

endmodule
`default_nettype wire

// File: rtl/nv_fifo_rwsp_128x6.sv
`default_nettype none
// ============================================================================
// Module      : nv_fifo_rwsp_128x6
// Description : 128-entry x 6-bit valid/ready FIFO backed by nv_ram_rwsp_128x6.
//               A two-stage prefetch pipeline (s1 = address register loaded,
//               s2 = output register loaded) hides the RAM read latency and
//               sustains one push and one pop per cycle.
// Ports       : clk, rst (async, active high)
//               wr_pvld_i / wr_prdy_o / wr_pd_i   push interface
//               rd_pvld_o / rd_prdy_i / rd_pd_o   pop interface
//               wr_count_o                        occupancy 0..128
//               pwrbus_ram_pd_i                   forwarded to the RAM
// Revision    : 1.0 - initial release
// ============================================================================
module nv_fifo_rwsp_128x6
    import nv_fifo_rwsp_128x6_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_pvld_i,
    output logic             wr_prdy_o,
    input  logic [WIDTH-1:0] wr_pd_i,
    output logic             rd_pvld_o,
    input  logic             rd_prdy_i,
    output logic [WIDTH-1:0] rd_pd_o,
    output logic [CW-1:0]    wr_count_o,
    input  logic [31:0]      pwrbus_ram_pd_i
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    unissued_q, unissued_d;
    logic [CW-1:0]    count_q, count_d;
    logic             s1_vld_q, s1_vld_d;
    logic             s2_vld_q, s2_vld_d;

    logic             w_push;
    logic             w_pop;
    logic             w_re;
    logic             w_ore;
    logic [WIDTH-1:0] w_dout;

    // Full flag depends only on registered occupancy, never on wr_pvld_i.
    assign wr_prdy_o = (count_q != CW'(DEPTH));
    assign w_push    = wr_pvld_i && wr_prdy_o;
    assign w_pop     = s2_vld_q && rd_prdy_i;

    // Stage 1 -> 2 advances when the output register is empty or draining.
    assign w_ore = s1_vld_q && (!s2_vld_q || rd_prdy_i);
    // Issue when a written-but-unread word exists and stage 1 can take it.
    // unissued_q is registered, so a word is never read in its write cycle.
    assign w_re  = (unissued_q != '0) && (!s1_vld_q || w_ore);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        unissued_d = unissued_q;
        count_d    = count_q;
        s1_vld_d   = s1_vld_q;
        s2_vld_d   = s2_vld_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_re) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({w_push, w_re})
            2'b10:   unissued_d = unissued_q + CW'(1);
            2'b01:   unissued_d = unissued_q - CW'(1);
            default: unissued_d = unissued_q;
        endcase

        // A slot is released only on pop, so in-flight words are never
        // overwritten by a new push.
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (w_re) begin
            s1_vld_d = 1'b1;
        end else if (w_ore) begin
            s1_vld_d = 1'b0;
        end

        if (w_ore) begin
            s2_vld_d = 1'b1;
        end else if (w_pop) begin
            s2_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            unissued_q <= '0;
            count_q    <= '0;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            unissued_q <= unissued_d;
            count_q    <= count_d;
            s1_vld_q   <= s1_vld_d;
            s2_vld_q   <= s2_vld_d;
        end
    end

    nv_ram_rwsp_128x6 u_ram (
        .clk             (clk),
        .ra_i            (rd_ptr_q),
        .re_i            (w_re),
        .ore_i           (w_ore),
        .dout_o          (w_dout),
        .wa_i            (wr_ptr_q),
        .we_i            (w_push),
        .di_i            (wr_pd_i),
        .pwrbus_ram_pd_i (pwrbus_ram_pd_i)
    );

    // The output register is not reset; mask it whenever nothing is valid.
    assign rd_pvld_o  = s2_vld_q;
    assign rd_pd_o    = w_dout & {WIDTH{s2_vld_q}};
    assign wr_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_nv_fifo_rwsp_128x6.sv
`default_nettype none
// ============================================================================
// Module      : tb_nv_fifo_rwsp_128x6
// Description : Directed self-checking bench for nv_fifo_rwsp_128x6.
//               Inputs change 1ns after the rising edge; outputs are
//               sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nv_fifo_rwsp_128x6;

    logic       clk;
    logic       rst;
    logic       wr_pvld;
    logic       wr_prdy;
    logic [5:0] wr_pd;
    logic       rd_pvld;
    logic       rd_prdy;
    logic [5:0] rd_pd;
    logic [7:0] wr_count;
    logic [31:0] pwrbus;

    int checks = 0;
    int errors = 0;

    nv_fifo_rwsp_128x6 dut (
        .clk             (clk),
        .rst             (rst),
        .wr_pvld_i       (wr_pvld),
        .wr_prdy_o       (wr_prdy),
        .wr_pd_i         (wr_pd),
        .rd_pvld_o       (rd_pvld),
        .rd_prdy_i       (rd_prdy),
        .rd_pd_o         (rd_pd),
        .wr_count_o      (wr_count),
        .pwrbus_ram_pd_i (pwrbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0; pwrbus = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (wr_prdy !== 1'b1) begin errors++; $display("FAIL reset_wr_prdy got %b exp 1", wr_prdy); end
        checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL reset_rd_pvld got %b exp 0", rd_pvld); end
        checks++; if (rd_pd !== 6'h00) begin errors++; $display("FAIL reset_rd_pd got %h exp 00", rd_pd); end
        checks++; if (wr_count !== 8'd0) begin errors++; $display("FAIL reset_wr_count got %0d exp 0", wr_count); end
        next_cycle();
    endtask

    task automatic test_single_word();
        wr_pvld = 1'b1; wr_pd = 6'h2A; rd_prdy = 1'b1;
        @(negedge clk);
        checks++; if (wr_count !== 8'd0) begin errors++; $display("FAIL single_c0_count got %0d exp 0", wr_count); end
        next_cycle();
        wr_pvld = 1'b0; wr_pd = '0;
        @(negedge clk);
        checks++; if (wr_count !== 8'd1) begin errors++; $display("FAIL single_c1_count got %0d exp 1", wr_count); end
        checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL single_c1_pvld got %b exp 0", rd_pvld); end
        next_cycle();
        @(negedge clk);
        checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL single_c2_pvld got %b exp 0", rd_pvld); end
        next_cycle();
        @(negedge clk);
        checks++; if (rd_pvld !== 1'b1) begin errors++; $display("FAIL single_c3_pvld got %b exp 1", rd_pvld); end
        checks++; if (rd_pd !== 6'h2A) begin errors++; $display("FAIL single_c3_pd got %h exp 2a", rd_pd); end
        checks++; if (wr_count !== 8'd1) begin errors++; $display("FAIL single_c3_count got %0d exp 1", wr_count); end
        next_cycle();
        @(negedge clk);
        checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL single_c4_pvld got %b exp 0", rd_pvld); end
        checks++; if (rd_pd !== 6'h00) begin errors++; $display("FAIL single_c4_pd got %h exp 00", rd_pd); end
        checks++; if (wr_count !== 8'd0) begin errors++; $display("FAIL single_c4_count got %0d exp 0", wr_count); end
        next_cycle();
    endtask

    task automatic test_streaming();
        int sent, got, cyc, first_pop, maxc;
        sent = 0; got = 0; cyc = 0; first_pop = -1; maxc = 0;
        rd_prdy = 1'b1;
        while (got < 200 && cyc < 400) begin
            wr_pvld = (sent < 200);
            wr_pd   = sent[5:0];
            @(negedge clk);
            if (int'(wr_count) > maxc) maxc = int'(wr_count);
            if (wr_pvld && wr_prdy) sent++;
            if (rd_pvld && rd_prdy) begin
                checks++;
                if (rd_pd !== 6'(got)) begin errors++; $display("FAIL stream_data idx %0d got %h exp %h", got, rd_pd, 6'(got)); end
                if (first_pop < 0) first_pop = cyc;
                checks++;
                if (cyc != first_pop + got) begin errors++; $display("FAIL stream_rate idx %0d cycle %0d exp %0d", got, cyc, first_pop + got); end
                got++;
            end
            next_cycle();
            cyc++;
        end
        wr_pvld = 1'b0;
        checks++; if (got != 200) begin errors++; $display("FAIL stream_timeout popped %0d exp 200", got); end
        checks++; if (first_pop != 3) begin errors++; $display("FAIL stream_latency first pop cycle %0d exp 3", first_pop); end
        checks++; if (maxc > 3) begin errors++; $display("FAIL stream_maxcount got %0d exp <=3", maxc); end
    endtask

    task automatic test_fill_full();
        int accepted, got, cyc;
        logic [5:0] exp_pd;
        accepted = 0;
        rd_prdy = 1'b0;
        for (int i = 0; i < 130; i++) begin
            wr_pvld = 1'b1;
            wr_pd   = 6'(i);
            @(negedge clk);
            checks++;
            if (wr_prdy !== (accepted < 128)) begin errors++; $display("FAIL full_prdy cycle %0d got %b exp %b", i, wr_prdy, (accepted < 128)); end
            checks++;
            if (int'(wr_count) != accepted) begin errors++; $display("FAIL full_count cycle %0d got %0d exp %0d", i, wr_count, accepted); end
            if (wr_prdy) accepted++;
            next_cycle();
        end
        checks++; if (accepted != 128) begin errors++; $display("FAIL full_accepted got %0d exp 128", accepted); end

        // Pop while full with a push pending: push must be blocked this cycle.
        wr_pvld = 1'b1; wr_pd = 6'h00; rd_prdy = 1'b1;
        @(negedge clk);
        checks++; if (wr_prdy !== 1'b0) begin errors++; $display("FAIL simul_prdy got %b exp 0", wr_prdy); end
        checks++; if (wr_count !== 8'd128) begin errors++; $display("FAIL simul_count got %0d exp 128", wr_count); end
        checks++; if (rd_pvld !== 1'b1 || rd_pd !== 6'h00) begin errors++; $display("FAIL simul_head got %b/%h exp 1/00", rd_pvld, rd_pd); end
        next_cycle();
        rd_prdy = 1'b0;
        @(negedge clk);
        checks++; if (wr_count !== 8'd127) begin errors++; $display("FAIL after_pop_count got %0d exp 127", wr_count); end
        checks++; if (wr_prdy !== 1'b1) begin errors++; $display("FAIL after_pop_prdy got %b exp 1", wr_prdy); end
        checks++; if (rd_pvld !== 1'b1 || rd_pd !== 6'h01) begin errors++; $display("FAIL after_pop_head got %b/%h exp 1/01", rd_pvld, rd_pd); end
        next_cycle();
        wr_pvld = 1'b0;
        @(negedge clk);
        checks++; if (wr_count !== 8'd128) begin errors++; $display("FAIL refill_count got %0d exp 128", wr_count); end
        checks++; if (wr_prdy !== 1'b0) begin errors++; $display("FAIL refill_prdy got %b exp 0", wr_prdy); end
        next_cycle();

        // Drain: words 1..128 of the fill sequence remain (6-bit values).
        rd_prdy = 1'b1; got = 0; cyc = 0;
        while (got < 128 && cyc < 400) begin
            @(negedge clk);
            if (rd_pvld) begin
                exp_pd = 6'(got + 1);
                checks++;
                if (rd_pd !== exp_pd) begin errors++; $display("FAIL drain_data idx %0d got %h exp %h", got, rd_pd, exp_pd); end
                got++;
            end
            next_cycle();
            cyc++;
        end
        checks++; if (got != 128) begin errors++; $display("FAIL drain_timeout popped %0d exp 128", got); end
        @(negedge clk);
        checks++; if (wr_count !== 8'd0 || rd_pvld !== 1'b0) begin errors++; $display("FAIL drain_empty count %0d pvld %b exp 0/0", wr_count, rd_pvld); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [5:0] q[$];
        logic [5:0] exp_pd, prev_pd;
        int pushed, popped, cyc, mcount;
        bit prev_stall;
        pushed = 0; popped = 0; cyc = 0; mcount = 0; prev_stall = 1'b0; prev_pd = '0;
        while (popped < 1000 && cyc < 20000) begin
            wr_pvld = (pushed < 1000) && ($urandom_range(3) != 0);
            wr_pd   = 6'($urandom);
            rd_prdy = $urandom_range(1);
            @(negedge clk);
            checks++;
            if (int'(wr_count) != mcount) begin errors++; $display("FAIL bp_count cycle %0d got %0d exp %0d", cyc, wr_count, mcount); end
            if (prev_stall) begin
                checks++;
                if (rd_pvld !== 1'b1 || rd_pd !== prev_pd) begin errors++; $display("FAIL bp_stable cycle %0d got %b/%h exp 1/%h", cyc, rd_pvld, rd_pd, prev_pd); end
            end
            if (!rd_pvld) begin
                checks++;
                if (rd_pd !== 6'h00) begin errors++; $display("FAIL bp_pd_mask cycle %0d got %h exp 00", cyc, rd_pd); end
            end
            if (wr_pvld && wr_prdy) begin
                q.push_back(wr_pd);
                pushed++;
                mcount++;
            end
            if (rd_pvld && rd_prdy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bp_extra pop cycle %0d got %h exp none", cyc, rd_pd);
                end else begin
                    exp_pd = q.pop_front();
                    if (rd_pd !== exp_pd) begin errors++; $display("FAIL bp_data idx %0d got %h exp %h", popped, rd_pd, exp_pd); end
                end
                popped++;
                mcount--;
            end
            prev_stall = rd_pvld && !rd_prdy;
            prev_pd    = rd_pd;
            next_cycle();
            cyc++;
        end
        wr_pvld = 1'b0; rd_prdy = 1'b1;
        checks++; if (popped != 1000 || q.size() != 0) begin errors++; $display("FAIL bp_done popped %0d left %0d exp 1000/0", popped, q.size()); end
    endtask

    task automatic test_reset_mid();
        rd_prdy = 1'b0;
        for (int i = 0; i < 50; i++) begin
            wr_pvld = 1'b1;
            wr_pd   = 6'(i + 7);
            next_cycle();
        end
        wr_pvld = 1'b0;
        @(negedge clk);
        checks++; if (rd_pvld !== 1'b1 || wr_count !== 8'd50) begin errors++; $display("FAIL mid_pre got %b/%0d exp 1/50", rd_pvld, wr_count); end
        next_cycle();
        #1;
        rst = 1'b1;
        #1;
        checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL mid_rst_pvld got %b exp 0", rd_pvld); end
        checks++; if (wr_count !== 8'd0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", wr_count); end
        checks++; if (wr_prdy !== 1'b1) begin errors++; $display("FAIL mid_rst_prdy got %b exp 1", wr_prdy); end
        checks++; if (rd_pd !== 6'h00) begin errors++; $display("FAIL mid_rst_pd got %h exp 00", rd_pd); end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = 6'h15;
        @(negedge clk);
        checks++; if (wr_count !== 8'd0 || rd_pvld !== 1'b0) begin errors++; $display("FAIL post_c0 got %0d/%b exp 0/0", wr_count, rd_pvld); end
        next_cycle();
        wr_pvld = 1'b0; wr_pd = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (k == 3) begin
                if (rd_pvld !== 1'b1 || rd_pd !== 6'h15) begin errors++; $display("FAIL post_pop cycle %0d got %b/%h exp 1/15", k, rd_pvld, rd_pd); end
            end else begin
                if (rd_pvld !== 1'b0) begin errors++; $display("FAIL post_stale cycle %0d got %b/%h exp 0", k, rd_pvld, rd_pd); end
            end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (wr_count !== 8'd0) begin errors++; $display("FAIL post_count got %0d exp 0", wr_count); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_streaming();
        test_fill_full();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
